shift_seq8: RTL and testbench

- Upstream command sequencer for the 8-bit shifter stage. That stage shifts at most 3 bits per cycle and registers its result on every clock.
- Accepts one command per valid/ready handshake: 8-bit data, a direction, and a shift amount of 0..7.
- Issues one LOAD, then as many shift steps as needed, each of at most 3 bits, on the shifter's op/shamt/d_in inputs.
- Pulses done when the shifter's registered output holds the final result.

---
 rtl/shift_pkg.sv | 35 +++
 rtl/seq_step_calc.sv | 17 +
 rtl/shift_seq8.sv | 91 +++++++++
 tb/tb_shift_seq8.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the 8-bit shifter stage and its command sequencer.
package shift_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;

  localparam logic [1:0] CMD_LOAD = 2'b00;
  localparam logic [1:0] CMD_LSL  = 2'b01;
  localparam logic [1:0] CMD_LSR  = 2'b10;
  localparam logic [1:0] CMD_ASR  = 2'b11;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned MAX_STEP = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  // A load-only command carries no shift direction, so it maps to NOP.
  function automatic logic [2:0] cmd_to_shop(input logic [1:0] c);
    case (c)
      CMD_LSL: return OP_LSL;
      CMD_LSR: return OP_LSR;
      CMD_ASR: return OP_ASR;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/seq_step_calc.sv
// Greedy step splitter: takes up to 3 bits from the remaining shift amount.
module seq_step_calc
  import shift_pkg::*;
(
  input  logic [2:0] rem,
  output logic [1:0] step,
  output logic [2:0] rem_next,
  output logic       last
);

  always_comb begin
    step     = (rem > 3'(MAX_STEP)) ? 2'(MAX_STEP) : rem[1:0];
    rem_next = rem - {1'b0, step};
    last     = (rem_next == 3'd0);
  end

endmodule

// File: rtl/shift_seq8.sv
// Command sequencer for the 8-bit shifter: one LOAD, then greedy <=3-bit shift steps,
// with a done pulse in the cycle the shifter's registered output holds the result.
module shift_seq8
  import shift_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_amt,
  input  logic [7:0] cmd_data,
  output logic [2:0] sh_op,
  output logic [1:0] sh_shamt,
  output logic [7:0] sh_din,
  output logic       busy,
  output logic       done
);

  state_t     state, state_nx;
  logic [2:0] rem;
  logic [2:0] dir;
  logic [7:0] data_q;

  logic [1:0] step;
  logic [2:0] rem_next;
  logic       last;
  logic       accept;

  seq_step_calc u_step (
    .rem      (rem),
    .step     (step),
    .rem_next (rem_next),
    .last     (last)
  );

  assign cmd_ready = (state == IDLE) || (state == DONE);
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rem    <= '0;
      dir    <= OP_NOP;
      data_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        data_q <= cmd_data;
        rem    <= (cmd_op == CMD_LOAD) ? 3'd0 : cmd_amt;
        dir    <= cmd_to_shop(cmd_op);
      end else if (state == SHIFT) begin
        rem <= rem_next;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? LOAD : IDLE;
      LOAD:    state_nx = (rem != 3'd0) ? SHIFT : DONE;
      SHIFT:   state_nx = last ? DONE : SHIFT;
      DONE:    state_nx = accept ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Moore outputs only: nothing on cmd_* reaches sh_* without a register in between.
  always_comb begin
    sh_op    = OP_NOP;
    sh_shamt = 2'b00;
    sh_din   = data_q;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      LOAD: begin
        sh_op = OP_LOAD;
        busy  = 1'b1;
      end
      SHIFT: begin
        sh_op    = dir;
        sh_shamt = step;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_seq8.sv
// Bench for shift_seq8: behavioural shifter stage plus a whole-shift reference result.
module tb_shift_seq8;
  import shift_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_amt = 3'd0;
  logic [7:0] cmd_data = 8'h00;
  logic [2:0] sh_op;
  logic [1:0] sh_shamt;
  logic [7:0] sh_din;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  logic [7:0]  sh_q;
  int          step_cnt;
  logic [15:0] step_code;
  logic [2:0]  shift_op_seen;
  bit          op_mixed;
  logic [2:0]  first_op;

  shift_seq8 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_data  (cmd_data),
    .sh_op     (sh_op),
    .sh_shamt  (sh_shamt),
    .sh_din    (sh_din),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Downstream shifter stage: registers its result every clock.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) sh_q <= 8'h00;
    else begin
      case (sh_op)
        OP_LOAD: sh_q <= sh_din;
        OP_LSL:  sh_q <= sh_q << sh_shamt;
        OP_LSR:  sh_q <= sh_q >> sh_shamt;
        OP_ASR:  sh_q <= $signed(sh_q) >>> sh_shamt;
        default: sh_q <= sh_q;
      endcase
    end
  end

  function automatic logic [7:0] ref_result(input logic [1:0] op, input logic [2:0] amt,
                                            input logic [7:0] data);
    logic signed [7:0] s;
    s = data;
    case (op)
      2'd1:    return data << amt;
      2'd2:    return data >> amt;
      2'd3:    return s >>> amt;
      default: return data;
    endcase
  endfunction

  function automatic logic [2:0] ref_op(input logic [1:0] op);
    case (op)
      2'd1:    return 3'd2;
      2'd2:    return 3'd3;
      2'd3:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic int ref_k(input logic [1:0] op, input logic [2:0] amt);
    return (op == 2'd0) ? 0 : (int'(amt) + 2) / 3;
  endfunction

  // Greedy split as a 2-bit-per-step code: all 3s first, remainder last.
  function automatic logic [15:0] ref_code(input logic [1:0] op, input logic [2:0] amt);
    logic [15:0] c;
    int a;
    c = 16'h0;
    a = (op == 2'd0) ? 0 : int'(amt);
    for (int i = 0; i < a / 3; i++) c = {c[13:0], 2'd3};
    if (a % 3 != 0) c = {c[13:0], 2'(a % 3)};
    return c;
  endfunction

  task automatic accept_cmd(input logic [1:0] op, input logic [2:0] amt, input logic [7:0] data,
                            input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    cmd_data  = data;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic [7:0] res, output int nbusy);
    step_cnt = 0; step_code = 16'h0; op_mixed = 0; shift_op_seen = OP_NOP; first_op = OP_NOP;
    lat = -1; res = 8'h00; nbusy = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) first_op = sh_op;
      if (busy) nbusy++;
      if (sh_op == OP_LSL || sh_op == OP_LSR || sh_op == OP_ASR) begin
        if (step_cnt > 0 && sh_op != shift_op_seen) op_mixed = 1;
        shift_op_seen = sh_op;
        step_cnt++;
        step_code = {step_code[13:0], sh_shamt};
      end
      if (done) begin
        lat = c;
        res = sh_q;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++; if (sh_op !== 3'b000) begin errors++; $display("FAIL reset_sh_op got=%0h exp=0", sh_op); end
    checks++; if (sh_shamt !== 2'b00) begin errors++; $display("FAIL reset_shamt got=%0h exp=0", sh_shamt); end
    checks++; if (sh_din !== 8'h00) begin errors++; $display("FAIL reset_din got=%0h exp=00", sh_din); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_plan();
    logic [1:0] ops[4]  = '{2'd1, 2'd3, 2'd2, 2'd0};
    logic [2:0] amts[4] = '{3'd5, 3'd7, 3'd0, 3'd7};
    logic [7:0] dats[4] = '{8'h81, 8'h80, 8'hA5, 8'h5A};
    int lat, nb, k;
    logic [7:0] res;
    for (int i = 0; i < 4; i++) begin
      accept_cmd(ops[i], amts[i], dats[i], 1'b0);
      wait_done(lat, res, nb);
      k = ref_k(ops[i], amts[i]);
      checks++; if (lat !== 2 + k) begin errors++; $display("FAIL plan%0d_latency got=%0d exp=%0d", i, lat, 2 + k); end
      checks++; if (res !== ref_result(ops[i], amts[i], dats[i])) begin errors++; $display("FAIL plan%0d_result got=%0h exp=%0h", i, res, ref_result(ops[i], amts[i], dats[i])); end
      checks++; if (nb !== 1 + k) begin errors++; $display("FAIL plan%0d_busy got=%0d exp=%0d", i, nb, 1 + k); end
      checks++; if (step_cnt !== k || step_code !== ref_code(ops[i], amts[i])) begin errors++; $display("FAIL plan%0d_steps got=%0d/%0h exp=%0d/%0h", i, step_cnt, step_code, k, ref_code(ops[i], amts[i])); end
      checks++; if (first_op !== OP_LOAD) begin errors++; $display("FAIL plan%0d_first_op got=%0h exp=1", i, first_op); end
      if (k > 0) begin
        checks++; if (shift_op_seen !== ref_op(ops[i]) || op_mixed) begin errors++; $display("FAIL plan%0d_dir got=%0h exp=%0h", i, shift_op_seen, ref_op(ops[i])); end
      end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL plan%0d_done_pulse got=%b exp=0", i, done); end
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [2:0] amt;
    logic [7:0] d;
    int lat, nb, k;
    logic [7:0] res;
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      amt = 3'($urandom_range(0, 7));
      d   = 8'($urandom);
      accept_cmd(op, amt, d, 1'b0);
      wait_done(lat, res, nb);
      k = ref_k(op, amt);
      checks++; if (lat !== 2 + k) begin errors++; $display("FAIL rand%0d_latency op=%0d amt=%0d got=%0d exp=%0d", i, op, amt, lat, 2 + k); end
      checks++; if (res !== ref_result(op, amt, d)) begin errors++; $display("FAIL rand%0d_result op=%0d amt=%0d d=%0h got=%0h exp=%0h", i, op, amt, d, res, ref_result(op, amt, d)); end
      checks++; if (step_code !== ref_code(op, amt) || step_cnt !== k) begin errors++; $display("FAIL rand%0d_steps got=%0d/%0h exp=%0d/%0h", i, step_cnt, step_code, k, ref_code(op, amt)); end
      if (k > 0) begin
        checks++; if (shift_op_seen !== ref_op(op) || op_mixed) begin errors++; $display("FAIL rand%0d_dir got=%0h exp=%0h", i, shift_op_seen, ref_op(op)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    logic [7:0] res;
    accept_cmd(2'd2, 3'd4, 8'hF0, 1'b1);
    cmd_op = 2'd1; cmd_amt = 3'd1; cmd_data = 8'h0F;
    wait_done(lat, res, nb);
    checks++; if (lat !== 4 || res !== 8'h0F) begin errors++; $display("FAIL b2b_first got=%0d/%0h exp=4/0f", lat, res); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done got=%b exp=1", cmd_ready); end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done(lat, res, nb);
    checks++; if (first_op !== OP_LOAD) begin errors++; $display("FAIL b2b_no_idle got=%0h exp=1", first_op); end
    checks++; if (lat !== 3 || res !== 8'h1E) begin errors++; $display("FAIL b2b_second got=%0d/%0h exp=3/1e", lat, res); end
  endtask

  task automatic test_backpressure();
    int lat, nb;
    logic [7:0] res;
    accept_cmd(2'd3, 3'd7, 8'h80, 1'b0);
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_amt = 3'd2; cmd_data = 8'h3C;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_shift got=%b exp=0", cmd_ready); end
    @(negedge clk);
    checks++; if (sh_op !== OP_ASR || sh_shamt !== 2'd3 || sh_din !== 8'h80) begin errors++; $display("FAIL bp_shift2 got=%0h/%0h/%0h exp=4/3/80", sh_op, sh_shamt, sh_din); end
    @(negedge clk);
    checks++; if (sh_op !== OP_ASR || sh_shamt !== 2'd1) begin errors++; $display("FAIL bp_shift3 got=%0h/%0h exp=4/1", sh_op, sh_shamt); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || sh_q !== 8'hFF || cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_done got=%b/%0h/%b exp=1/ff/1", done, sh_q, cmd_ready); end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done(lat, res, nb);
    checks++; if (lat !== 3 || res !== 8'hF0) begin errors++; $display("FAIL bp_held_cmd got=%0d/%0h exp=3/f0", lat, res); end
  endtask

  task automatic test_reset_mid();
    int lat, nb;
    logic [7:0] res;
    bit saw_done;
    accept_cmd(2'd3, 3'd7, 8'h80, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++; if (sh_op !== OP_ASR || busy !== 1'b1) begin errors++; $display("FAIL rst_pre got=%0h/%b exp=4/1", sh_op, busy); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (sh_op !== 3'b000 || sh_shamt !== 2'b00 || sh_din !== 8'h00) begin errors++; $display("FAIL rst_async_outputs got=%0h/%0h/%0h exp=0/0/00", sh_op, sh_shamt, sh_din); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_async_flags got=%b%b%b exp=001", busy, done, cmd_ready); end
    saw_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL rst_no_done got=1 exp=0"); end
    accept_cmd(2'd1, 3'd3, 8'h01, 1'b0);
    wait_done(lat, res, nb);
    checks++; if (lat !== 3 || res !== 8'h08) begin errors++; $display("FAIL rst_after got=%0d/%0h exp=3/08", lat, res); end
  endtask

  initial begin
    test_reset();
    test_plan();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
